scroll_sprite_addr_gen: RTL
===========================

// Module: scroll_sprite_addr_gen
// PURPOSE
//  Pipelined, parametrised frame-buffer address generator for the VGA path. Maps (h_cnt,v_cnt)
//  to a ROM pixel address for one image layer positioned at (pos_x,pos_y): tiled/wrapping
//  background (WRAP=1) or clipped sprite with hit flag (WRAP=0). Adds frame-synchronous position
//  latching and multi-frame sprite-sheet animation. Sits between vga_controller and the block ROM.
// PARAMETERS
//  IMG_W       320  image width in pixels
//  IMG_H       240  image height in pixels
//  FRAMES      1    animation frames stacked vertically in ROM (frame k at row offset k*IMG_H)
//  ANIM_DIV    6    frame_start pulses per animation step (>=1)
//  SCALE_SHIFT 1    screen-to-image downscale: h_addr=h_cnt>>SCALE_SHIFT, same for v
//  WRAP        1    1=tile with wrap-around, 0=clip outside image
//  POS_W/CNT_W/ADDR_W  9/10/17  position, counter, address widths
// PORTS
//  clk         in   1       pixel clock
//  rst         in   1       asynchronous reset, active-low
//  frame_start in   1       1-cycle pulse, once per video frame (vblank start)
//  pos_x,pos_y in   POS_W   image origin, image-pixel units; sampled only on frame_start
//  anim_en     in   1       1=advance animation, 0=hold current frame index
//  flip        in   1       horizontal mirror, sampled on frame_start (only with MIRROR_EN)
//  pix_valid   in   1       h_cnt/v_cnt valid this cycle
//  h_cnt,v_cnt in   CNT_W   screen counters
//  pixel_addr  out  ADDR_W  ROM address, registered
//  addr_valid  out  1       pixel_addr/hit correspond to a pix_valid input 3 cycles earlier
//  hit         out  1       pixel inside image (always 1 when WRAP=1)
// BEHAVIOUR
//  - rst low: all registers 0 immediately (pixel_addr=0, addr_valid=0, hit=0, shadows, anim).
//    Reset mid-operation discards in-flight pixels; first valid output 3 cycles after first pix_valid.
//  - Shadow regs px_q,py_q(,flip_q) load on frame_start edge; pixel sampled in same cycle as
//    frame_start uses pre-update values. Mid-frame pos changes never affect output.
//  - Anim: on frame_start with anim_en=1, div_cnt++; when div_cnt==ANIM_DIV-1 it clears and
//    anim_idx advances, FRAMES-1 -> 0. anim_en=0 holds div_cnt and anim_idx. FRAMES=1: idx stays 0.
//  - Pipeline, fixed latency 3, no stall, one pixel/cycle:
//    S1: dx = (h_cnt>>SCALE_SHIFT) - px_q, dy likewise; signed CNT_W+1 bits; register valid.
//    S2 WRAP=1: normalise dx into [0,IMG_W) by one correction from {+2W,+W,0,-W,-2W}; same for dy
//       with IMG_H. Elaboration check: dx/dy range within [-2*IMG_W,3*IMG_W) (resp. H), else $error.
//    S2 WRAP=0: hit = 0<=dx<IMG_W && 0<=dy<IMG_H; x,y = dx,dy if hit else 0.
//    S3: pixel_addr = x + IMG_W*(y + anim_idx*IMG_H), constant-coefficient multiply, registered.
//       anim_idx sampled in S1 with the pixel. Miss: pixel_addr=0, hit=0, addr_valid still 1.
//  - pix_valid=0: bubble propagates; addr_valid=0, pixel_addr/hit hold previous values.
//  - No % operators; ADDR_W must cover IMG_W*IMG_H*FRAMES-1 (elaboration check).
// CONFIGURATION
//  MIRROR_EN defined: flip port exists; when flip_q=1, S2 x := IMG_W-1-x after wrap/clip (hit
//  unchanged). Undefined: no flip port, no flip_q, x passes unmodified.
// STRUCTURE
//  Package dino_gfx_pkg: SCREEN_W=320, SCREEN_H=240, POS_W, CNT_W, ADDR_W constants.
//  Sub-module anim_frame_ctr (div_cnt + anim_idx, params FRAMES, ANIM_DIV); rest inline.
// TESTING
//  1 WRAP=1 320x240: frame_start with pos=(10,0); h_cnt=0,v_cnt=0 -> 3 cycles later addr=310,
//    hit=1; h_cnt=20 -> addr=0; h_cnt=18,v_cnt=2 -> addr=320+319=639.
//  2 WRAP=0 24x28 FRAMES=2, pos=(100,50): (200,100)->addr 0 hit 1; (246,154)->671 hit 1;
//    (248,154)->addr 0 hit 0; (198,100)->hit 0.
//  3 Anim ANIM_DIV=6 FRAMES=2 anim_en=1: after 6 frame_start, (200,100)->672; after 12 -> 0;
//    anim_en=0 across 10 pulses -> index unchanged.
//  4 Shadow: change pos_x 100->120 mid-frame -> addresses unchanged until next frame_start;
//    pixel coincident with frame_start uses pos_x=100.
//  5 Reset: assert rst low with 3 pixels in flight -> addr_valid/hit/pixel_addr 0 at once, no
//    stale outputs after release; anim_idx=0.
//  6 MIRROR_EN, case 2 setup, flip=1: (200,100)->addr 23; (246,154)->648; off: port absent.

Source files
------------

// File: rtl/dino_gfx_pkg.sv
// Shared constants and helpers for the VGA graphics path.
package dino_gfx_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int POS_W    = 9;
  localparam int CNT_W    = 10;
  localparam int ADDR_W   = 17;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Single correction from {+2n,+n,0,-n,-2n}; v must lie in [-2n,3n).
  function automatic int wrap_norm(input int v, input int n);
    if (v < -n)         return v + 2 * n;
    else if (v < 0)     return v + n;
    else if (v < n)     return v;
    else if (v < 2 * n) return v - n;
    else                return v - 2 * n;
  endfunction
endpackage

// File: rtl/anim_frame_ctr.sv
// Sprite-sheet animation: divides frame_start pulses by ANIM_DIV and steps a frame index.
module anim_frame_ctr
  import dino_gfx_pkg::*;
#(
  parameter int FRAMES   = 1,
  parameter int ANIM_DIV = 6,
  parameter int IDX_W    = clog2_min1(FRAMES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             anim_en,
  output logic [IDX_W-1:0] anim_idx
);
  localparam int DW = clog2_min1(ANIM_DIV);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      anim_idx <= '0;
    end else if (frame_start && anim_en) begin
      if (div_cnt == DW'(ANIM_DIV - 1)) begin
        div_cnt  <= '0;
        anim_idx <= (anim_idx == IDX_W'(FRAMES - 1)) ? '0 : anim_idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/scroll_sprite_addr_gen.sv
// Screen (h_cnt,v_cnt) -> layer ROM address, 3-stage pipeline, wrap or clip.
// Optional horizontal mirror via MIRROR_EN.
module scroll_sprite_addr_gen
  import dino_gfx_pkg::*;
#(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int FRAMES      = 1,
  parameter int ANIM_DIV    = 6,
  parameter int SCALE_SHIFT = 1,
  parameter int WRAP        = 1,
  parameter int POS_W       = dino_gfx_pkg::POS_W,
  parameter int CNT_W       = dino_gfx_pkg::CNT_W,
  parameter int ADDR_W      = dino_gfx_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [POS_W-1:0]  pos_x,
  input  logic [POS_W-1:0]  pos_y,
  input  logic              anim_en,
`ifdef MIRROR_EN
  input  logic              flip,
`endif
  input  logic              pix_valid,
  input  logic [CNT_W-1:0]  h_cnt,
  input  logic [CNT_W-1:0]  v_cnt,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              addr_valid,
  output logic              hit
);
  localparam int STAGES = 3;
  localparam int IDX_W  = clog2_min1(FRAMES);
  localparam int XW     = clog2_min1(IMG_W);
  localparam int YW     = clog2_min1(IMG_H);

  // Positions and scaled counters are assumed to stay on-screen, bounding dx/dy.
  if (WRAP != 0) begin : g_wrap_chk
    if ((SCREEN_W - 1) >= 3 * IMG_W || (SCREEN_W - 1) > 2 * IMG_W ||
        (SCREEN_H - 1) >= 3 * IMG_H || (SCREEN_H - 1) > 2 * IMG_H) begin : g_err
      $error("dx/dy range exceeds single-correction wrap window");
    end
  end
  if (longint'(IMG_W) * IMG_H * FRAMES - 1 >= (longint'(1) << ADDR_W)) begin : g_addr_chk
    $error("ADDR_W too narrow for IMG_W*IMG_H*FRAMES");
  end

  logic [POS_W-1:0]  px_q, py_q;
  logic [IDX_W-1:0]  anim_idx, idx_s1, idx_s2;
  logic [STAGES-1:0] vld_pipe;
  logic [CNT_W-1:0]  hs, vs;
  logic signed [CNT_W:0] dx_q, dy_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              hit_q, hit_d;
  int                xi, yi;
`ifdef MIRROR_EN
  logic              flip_q, flip_s1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px_q <= '0;
      py_q <= '0;
`ifdef MIRROR_EN
      flip_q <= 1'b0;
`endif
    end else if (frame_start) begin
      px_q <= pos_x;
      py_q <= pos_y;
`ifdef MIRROR_EN
      flip_q <= flip;
`endif
    end
  end

  anim_frame_ctr #(.FRAMES(FRAMES), .ANIM_DIV(ANIM_DIV), .IDX_W(IDX_W)) u_anim (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .anim_en    (anim_en),
    .anim_idx   (anim_idx)
  );

  assign hs = h_cnt >> SCALE_SHIFT;
  assign vs = v_cnt >> SCALE_SHIFT;

  // S2 combinational: wrap or clip, then optional mirror
  always_comb begin
    xi    = int'(dx_q);
    yi    = int'(dy_q);
    hit_d = 1'b1;
    if (WRAP != 0) begin
      xi = wrap_norm(xi, IMG_W);
      yi = wrap_norm(yi, IMG_H);
    end else begin
      hit_d = (xi >= 0) && (xi < IMG_W) && (yi >= 0) && (yi < IMG_H);
      if (!hit_d) begin
        xi = 0;
        yi = 0;
      end
    end
`ifdef MIRROR_EN
    if (flip_s1) xi = IMG_W - 1 - xi;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe   <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      idx_s1     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      hit_q      <= 1'b0;
      idx_s2     <= '0;
      pixel_addr <= '0;
      hit        <= 1'b0;
`ifdef MIRROR_EN
      flip_s1    <= 1'b0;
`endif
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], pix_valid};
      // S1
      dx_q   <= $signed({1'b0, hs}) - $signed({{(CNT_W + 1 - POS_W){1'b0}}, px_q});
      dy_q   <= $signed({1'b0, vs}) - $signed({{(CNT_W + 1 - POS_W){1'b0}}, py_q});
      idx_s1 <= anim_idx;
`ifdef MIRROR_EN
      flip_s1 <= flip_q;
`endif
      // S2
      x_q    <= XW'(xi);
      y_q    <= YW'(yi);
      hit_q  <= hit_d;
      idx_s2 <= idx_s1;
      // S3: bubbles leave the output registers untouched
      if (vld_pipe[1]) begin
        pixel_addr <= hit_q ? ADDR_W'(x_q) + ADDR_W'(IMG_W) *
                              (ADDR_W'(y_q) + ADDR_W'(IMG_H) * ADDR_W'(idx_s2))
                            : '0;
        hit        <= hit_q;
      end
    end
  end

  assign addr_valid = vld_pipe[STAGES-1];
endmodule
